vdp_layer_window_ctrl: RTL and testbench
========================================

Name: vdp_layer_window_ctrl

Overview:
Per-pixel layer gating controller that sits ahead of the layer priority selector and produces its 5-bit layer_mask. It combines the per-layer opacity flags from the pixel fetch stages with host-programmed layer enables and one rectangular window that hides selected layers. Host register writes go to staging copies and commit atomically at frame start, so configuration never changes mid-frame.

Parameters:
X_WIDTH, 10, width of raster X counter and window X bounds
Y_WIDTH, 10, width of raster Y counter and window Y bounds

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
reg_write_en  input  1  host register write strobe, one write per asserted cycle
reg_address  input  3  register select
reg_data  input  16  write data, LSB-aligned
frame_start  input  1  one-cycle pulse at the first cycle of a frame
line_start  input  1  one-cycle pulse at the first cycle of each line
pixel_valid  input  1  opaque_mask is valid for the current pixel
opaque_mask  input  5  bit0-3 scroll0-3 opaque, bit4 sprite opaque
layer_mask  output  5  gated mask for the priority selector, registered
layer_mask_valid  output  1  layer_mask is valid, registered
window_hit  output  1  current output pixel lies inside the effective window
commit_pending  output  1  staging differs from active because writes arrived since the last commit

Behaviour:
- Register map (staging): 0 layer_enable[4:0]; 1 win_x_start; 2 win_x_end; 3 win_y_start; 4 win_y_end; 5 win_layer_sel[4:0]; 6 win_invert[0]; 7 reserved (write ignored, does not set commit_pending). Unused upper data bits are ignored.
- Reset values: staging and active layer_enable = 5'b11111; all other staging and active registers = 0; x_count = 0; y_count = 0; layer_mask = 0; layer_mask_valid = 0; window_hit = 0; commit_pending = 0.
- Commit: on a frame_start cycle, every active register <= its staging value. A write in that same cycle is merged first, so active receives the newly written value. commit_pending clears on commit and sets on any write to addresses 0-6 in a non-frame_start cycle.
- X counter: cleared to 0 on line_start. Otherwise it increments by 1 on pixel_valid and saturates at all-ones. The pixel presented with pixel_valid uses the pre-increment value. If line_start and pixel_valid coincide, that pixel uses x = 0 and the counter becomes 1.
- Y counter: cleared to 0 on frame_start. It increments on line_start when frame_start is not asserted, and saturates at all-ones. Line 0 of a frame is the line whose line_start coincides with, or first follows, frame_start.
- Window test, using active registers: in_x = (win_x_start <= x <= win_x_end); in_y likewise for y. If start > end on an axis, that axis never matches. hit = (in_x && in_y) XOR win_invert.
- Output stage, 1-cycle latency, all registered:
  - layer_mask <= opaque_mask & layer_enable & ~(hit ? win_layer_sel : 0).
  - layer_mask_valid <= pixel_valid.
  - window_hit <= hit && pixel_valid.
  - On cycles without pixel_valid: layer_mask <= 0 and layer_mask_valid <= 0.
- Reset asserted mid-frame immediately forces all state to reset values. After reset deasserts, outputs remain in reset state until pixel_valid is seen. Counters restart at 0 and do not wait for frame_start.

Test Plan:
- After reset, pixel_valid with opaque_mask=5'b10101 -> layer_mask=5'b10101 and layer_mask_valid=1 one cycle later; commit_pending=0.
- Write reg0=5'b00011 mid-frame -> commit_pending=1 and layer_mask unchanged for the rest of the frame. After the next frame_start, opaque 5'b11111 -> layer_mask=5'b00011 and commit_pending=0.
- Window x 4..7, y 2..3, win_layer_sel=5'b10000, committed; all pixels opaque 5'b11111 -> on lines 2-3, pixels 4-7 give 5'b01111 with window_hit=1; every other pixel gives 5'b11111.
- Same window with win_invert=1 -> pixels outside the rectangle give 5'b01111; inside pixels give 5'b11111.
- win_x_start=9, win_x_end=3 -> window_hit never asserts in any line; with win_invert=1, window_hit asserts for every valid pixel.
- Write reg5 in the same cycle as frame_start -> new value active immediately and commit_pending stays 0. Asserting reset mid-line -> layer_mask=0, layer_mask_valid=0, and active registers return to reset values.

Source files
------------

// File: rtl/vdp_layer_window_ctrl.sv
// Per-pixel layer gating ahead of the layer priority selector.
// Host writes land in staging registers. Staging is copied to the active
// set at frame start, so the configuration stays fixed for a whole frame.
// The raster x/y position is tracked locally from the line_start and
// frame_start pulses. The window test and layer gating use that position
// and the active registers, and the result is registered.
//
// Handshake: pixel_valid qualifies opaque_mask for exactly the cycle it is
// high. No backpressure exists. Each valid input pixel yields one output
// pixel one cycle later, and layer_mask_valid marks that output pixel.
module vdp_layer_window_ctrl #(
   parameter int X_WIDTH = 10,
   parameter int Y_WIDTH = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write_en,
   input  logic [2:0]  reg_address,
   input  logic [15:0] reg_data,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic        pixel_valid,
   input  logic [4:0]  opaque_mask,
   output logic [4:0]  layer_mask,
   output logic        layer_mask_valid,
   output logic        window_hit,
   output logic        commit_pending
);

   // staging registers (host-visible)
   logic [4:0]         stg_en_q, stg_en_d;
   logic [X_WIDTH-1:0] stg_xs_q, stg_xs_d, stg_xe_q, stg_xe_d;
   logic [Y_WIDTH-1:0] stg_ys_q, stg_ys_d, stg_ye_q, stg_ye_d;
   logic [4:0]         stg_sel_q, stg_sel_d;
   logic               stg_inv_q, stg_inv_d;

   // active registers (used by the pixel path)
   logic [4:0]         act_en_q, act_en_d;
   logic [X_WIDTH-1:0] act_xs_q, act_xs_d, act_xe_q, act_xe_d;
   logic [Y_WIDTH-1:0] act_ys_q, act_ys_d, act_ye_q, act_ye_d;
   logic [4:0]         act_sel_q, act_sel_d;
   logic               act_inv_q, act_inv_d;

   logic               commit_pending_q, commit_pending_d;

   // raster position
   logic [X_WIDTH-1:0] x_q, x_d, x_cur;
   logic [Y_WIDTH-1:0] y_q, y_d, y_cur;
   logic               first_line_q, first_line_d;

   // output stage
   logic [4:0]         layer_mask_q, layer_mask_d;
   logic               layer_mask_valid_q, layer_mask_valid_d;
   logic               window_hit_q, window_hit_d;

   logic               in_x, in_y, hit;
   logic               cfg_write;
   logic               unused_data;

   // Not every data bit maps onto a register field.
   assign unused_data = ^reg_data;

   // Merge a host write into staging; frame_start commits the merged value.
   always_comb begin
      stg_en_d  = stg_en_q;
      stg_xs_d  = stg_xs_q;
      stg_xe_d  = stg_xe_q;
      stg_ys_d  = stg_ys_q;
      stg_ye_d  = stg_ye_q;
      stg_sel_d = stg_sel_q;
      stg_inv_d = stg_inv_q;
      cfg_write = 1'b0;
      if (reg_write_en) begin
         cfg_write = (reg_address != 3'd7);
         case (reg_address)
            3'd0: stg_en_d  = reg_data[4:0];
            3'd1: stg_xs_d  = reg_data[X_WIDTH-1:0];
            3'd2: stg_xe_d  = reg_data[X_WIDTH-1:0];
            3'd3: stg_ys_d  = reg_data[Y_WIDTH-1:0];
            3'd4: stg_ye_d  = reg_data[Y_WIDTH-1:0];
            3'd5: stg_sel_d = reg_data[4:0];
            3'd6: stg_inv_d = reg_data[0];
            default: ;
         endcase
      end

      act_en_d  = act_en_q;
      act_xs_d  = act_xs_q;
      act_xe_d  = act_xe_q;
      act_ys_d  = act_ys_q;
      act_ye_d  = act_ye_q;
      act_sel_d = act_sel_q;
      act_inv_d = act_inv_q;
      commit_pending_d = commit_pending_q;
      if (frame_start) begin
         act_en_d  = stg_en_d;
         act_xs_d  = stg_xs_d;
         act_xe_d  = stg_xe_d;
         act_ys_d  = stg_ys_d;
         act_ye_d  = stg_ye_d;
         act_sel_d = stg_sel_d;
         act_inv_d = stg_inv_d;
         commit_pending_d = 1'b0;
      end else if (cfg_write) begin
         commit_pending_d = 1'b1;
      end
   end

   // Raster position for this cycle's pixel and the next counter values.
   // The first line_start at or after frame_start is line 0 and does not advance y.
   always_comb begin
      x_cur = line_start ? '0 : x_q;
      x_d   = x_cur;
      if (pixel_valid && (x_cur != {X_WIDTH{1'b1}}))
         x_d = x_cur + X_WIDTH'(1);

      y_cur = y_q;
      if (frame_start)
         y_cur = '0;
      else if (line_start && !first_line_q && (y_q != {Y_WIDTH{1'b1}}))
         y_cur = y_q + Y_WIDTH'(1);
      y_d = y_cur;

      first_line_d = first_line_q;
      if (frame_start)
         first_line_d = !line_start;
      else if (line_start)
         first_line_d = 1'b0;
   end

   // Window test and gated mask for the output register.
   // The config used is the one committed at this edge, so the pixel that
   // shares a cycle with frame_start already sees the new frame's settings.
   always_comb begin
      in_x = (act_xs_d <= x_cur) && (x_cur <= act_xe_d);
      in_y = (act_ys_d <= y_cur) && (y_cur <= act_ye_d);
      hit  = (in_x && in_y) ^ act_inv_d;

      layer_mask_d       = '0;
      layer_mask_valid_d = 1'b0;
      window_hit_d       = 1'b0;
      if (pixel_valid) begin
         layer_mask_d       = opaque_mask & act_en_d & ~(hit ? act_sel_d : 5'b0);
         layer_mask_valid_d = 1'b1;
         window_hit_d       = hit;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg_en_q  <= 5'b11111;
         stg_xs_q  <= '0;
         stg_xe_q  <= '0;
         stg_ys_q  <= '0;
         stg_ye_q  <= '0;
         stg_sel_q <= '0;
         stg_inv_q <= 1'b0;
         act_en_q  <= 5'b11111;
         act_xs_q  <= '0;
         act_xe_q  <= '0;
         act_ys_q  <= '0;
         act_ye_q  <= '0;
         act_sel_q <= '0;
         act_inv_q <= 1'b0;
         commit_pending_q   <= 1'b0;
         x_q                <= '0;
         y_q                <= '0;
         first_line_q       <= 1'b1;
         layer_mask_q       <= '0;
         layer_mask_valid_q <= 1'b0;
         window_hit_q       <= 1'b0;
      end else begin
         stg_en_q  <= stg_en_d;
         stg_xs_q  <= stg_xs_d;
         stg_xe_q  <= stg_xe_d;
         stg_ys_q  <= stg_ys_d;
         stg_ye_q  <= stg_ye_d;
         stg_sel_q <= stg_sel_d;
         stg_inv_q <= stg_inv_d;
         act_en_q  <= act_en_d;
         act_xs_q  <= act_xs_d;
         act_xe_q  <= act_xe_d;
         act_ys_q  <= act_ys_d;
         act_ye_q  <= act_ye_d;
         act_sel_q <= act_sel_d;
         act_inv_q <= act_inv_d;
         commit_pending_q   <= commit_pending_d;
         x_q                <= x_d;
         y_q                <= y_d;
         first_line_q       <= first_line_d;
         layer_mask_q       <= layer_mask_d;
         layer_mask_valid_q <= layer_mask_valid_d;
         window_hit_q       <= window_hit_d;
      end
   end

   assign layer_mask       = layer_mask_q;
   assign layer_mask_valid = layer_mask_valid_q;
   assign window_hit       = window_hit_q;
   assign commit_pending   = commit_pending_q;

endmodule

// File: tb/tb_vdp_layer_window_ctrl.sv
// Directed bench for vdp_layer_window_ctrl. Each driven cycle pushes its
// expected output {valid, hit, mask} to a queue. The queue is popped and
// compared one clock later, when the registered output appears.
module tb_vdp_layer_window_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        reg_write_en;
   logic [2:0]  reg_address;
   logic [15:0] reg_data;
   logic        frame_start;
   logic        line_start;
   logic        pixel_valid;
   logic [4:0]  opaque_mask;
   logic [4:0]  layer_mask;
   logic        layer_mask_valid;
   logic        window_hit;
   logic        commit_pending;

   int checks = 0;
   int errors = 0;

   logic [6:0] exp_q[$];

   // bench copy of the register set: staged and in-effect
   logic [4:0] s_en, e_en, s_sel, e_sel;
   int         s_xs, s_xe, s_ys, s_ye, e_xs, e_xe, e_ys, e_ye;
   logic       s_inv, e_inv;

   vdp_layer_window_ctrl #(.X_WIDTH(10), .Y_WIDTH(10)) dut (
      .clk              (clk),
      .reset            (reset),
      .reg_write_en     (reg_write_en),
      .reg_address      (reg_address),
      .reg_data         (reg_data),
      .frame_start      (frame_start),
      .line_start       (line_start),
      .pixel_valid      (pixel_valid),
      .opaque_mask      (opaque_mask),
      .layer_mask       (layer_mask),
      .layer_mask_valid (layer_mask_valid),
      .window_hit       (window_hit),
      .commit_pending   (commit_pending)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic cfg_defaults();
      s_en = 5'b11111; s_sel = '0; s_inv = 1'b0;
      s_xs = 0; s_xe = 0; s_ys = 0; s_ye = 0;
      e_en = s_en; e_sel = s_sel; e_inv = s_inv;
      e_xs = s_xs; e_xe = s_xe; e_ys = s_ys; e_ye = s_ye;
   endtask

   task automatic commit();
      e_en = s_en; e_sel = s_sel; e_inv = s_inv;
      e_xs = s_xs; e_xe = s_xe; e_ys = s_ys; e_ye = s_ye;
   endtask

   task automatic stage(input logic [2:0] a, input logic [15:0] d);
      case (a)
         3'd0: s_en  = d[4:0];
         3'd1: s_xs  = int'(d[9:0]);
         3'd2: s_xe  = int'(d[9:0]);
         3'd3: s_ys  = int'(d[9:0]);
         3'd4: s_ye  = int'(d[9:0]);
         3'd5: s_sel = d[4:0];
         3'd6: s_inv = d[0];
         default: ;
      endcase
   endtask

   function automatic logic [6:0] exp_out(input logic pv, input logic [4:0] om,
                                          input int x, input int y);
      logic h;
      logic [4:0] m;
      if (!pv) return 7'd0;
      h = ((e_xs <= x) && (x <= e_xe) && (e_ys <= y) && (y <= e_ye)) ^ e_inv;
      m = om & e_en & ~(h ? e_sel : 5'b0);
      return {1'b1, h, m};
   endfunction

   task automatic check_out(input string tag, input logic [6:0] e);
      checks++;
      assert (layer_mask_valid === e[6]) else begin
         errors++;
         $error("FAIL %s valid obs=%0b exp=%0b", tag, layer_mask_valid, e[6]);
      end
      checks++;
      assert (window_hit === e[5]) else begin
         errors++;
         $error("FAIL %s window_hit obs=%0b exp=%0b", tag, window_hit, e[5]);
      end
      checks++;
      assert (layer_mask === e[4:0]) else begin
         errors++;
         $error("FAIL %s layer_mask obs=%b exp=%b", tag, layer_mask, e[4:0]);
      end
   endtask

   task automatic chk_cp(input string tag, input logic e);
      checks++;
      assert (commit_pending === e) else begin
         errors++;
         $error("FAIL %s commit_pending obs=%0b exp=%0b", tag, commit_pending, e);
      end
   endtask

   // one clock of stimulus; the expectation goes through the queue
   task automatic step(input logic we, input logic [2:0] a, input logic [15:0] d,
                       input logic fs, input logic ls, input logic pv,
                       input logic [4:0] om, input int x, input int y,
                       input string tag);
      logic [6:0] e;
      reg_write_en = we; reg_address = a; reg_data = d;
      frame_start = fs; line_start = ls; pixel_valid = pv; opaque_mask = om;
      exp_q.push_back(exp_out(pv, om, x, y));
      @(posedge clk);
      #1;
      reg_write_en = 1'b0; frame_start = 1'b0; line_start = 1'b0;
      pixel_valid = 1'b0; opaque_mask = '0;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard obs=empty exp=entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_out(tag, e);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      stage(a, d);
      step(1'b1, a, d, 1'b0, 1'b0, 1'b0, 5'b0, 0, 0, "wr");
   endtask

   task automatic frame();
      step(1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0, 5'b0, 0, 0, "frame");
      commit();
   endtask

   task automatic line(input int y, input int n, input logic [4:0] om, input string tag);
      for (int x = 0; x < n; x++)
         step(1'b0, 3'd0, 16'd0, 1'b0, (x == 0), 1'b1, om, x, y, tag);
   endtask

   initial begin
      reset = 1'b1;
      reg_write_en = 1'b0; reg_address = '0; reg_data = '0;
      frame_start = 1'b0; line_start = 1'b0; pixel_valid = 1'b0; opaque_mask = '0;
      cfg_defaults();
      repeat (3) @(posedge clk);
      #1;
      check_out("reset", 7'd0);
      chk_cp("reset", 1'b0);
      reset = 1'b0;

      // first pixel after reset, counters at 0 without any frame_start
      step(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 5'b10101, 0, 0, "first_px");
      chk_cp("first_px", 1'b0);

      // mid-frame write stays staged until the next frame
      frame();
      wr(3'd0, 16'h0003);
      chk_cp("staged", 1'b1);
      line(0, 4, 5'b11111, "staged_line");
      chk_cp("staged_hold", 1'b1);
      frame();
      chk_cp("committed", 1'b0);
      line(0, 4, 5'b11111, "en_line");

      // window x 4..7, y 2..3 hiding the sprite layer
      wr(3'd0, 16'h001f);
      wr(3'd1, 16'd4);
      wr(3'd2, 16'd7);
      wr(3'd3, 16'd2);
      wr(3'd4, 16'd3);
      wr(3'd5, 16'h0010);
      frame();
      for (int y = 0; y < 5; y++) line(y, 10, 5'b11111, "win");
      line(5, 6, 5'b10110, "win_pat");

      // same window, inverted
      wr(3'd6, 16'd1);
      frame();
      for (int y = 0; y < 5; y++) line(y, 10, 5'b11111, "win_inv");

      // x start beyond end: axis never matches
      wr(3'd6, 16'd0);
      wr(3'd1, 16'd9);
      wr(3'd2, 16'd3);
      frame();
      for (int y = 0; y < 4; y++) line(y, 10, 5'b11111, "empty_win");
      wr(3'd6, 16'hfffd);
      frame();
      for (int y = 0; y < 3; y++) line(y, 10, 5'b11111, "empty_inv");

      // write coincident with frame_start commits immediately
      wr(3'd0, 16'h0007);
      chk_cp("pre_fs_write", 1'b1);
      stage(3'd5, 16'h0001);
      step(1'b1, 3'd5, 16'h0001, 1'b1, 1'b0, 1'b0, 5'b0, 0, 0, "fs_write");
      commit();
      chk_cp("fs_write", 1'b0);
      wr(3'd7, 16'hffff);
      chk_cp("reserved_write", 1'b0);
      line(0, 6, 5'b11111, "fs_write_line");

      // reset asserted mid-line
      wr(3'd1, 16'd2);
      chk_cp("pre_reset", 1'b1);
      step(1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b1, 5'b11111, 0, 1, "pre_reset_px0");
      step(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 5'b11011, 1, 1, "pre_reset_px1");
      pixel_valid = 1'b1; opaque_mask = 5'b11111;
      reset = 1'b1;
      #1;
      check_out("async_reset", 7'd0);
      chk_cp("async_reset", 1'b0);
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      reset = 1'b0;
      cfg_defaults();
      step(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 0, 0, "post_reset_idle");
      step(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 5'b11111, 0, 0, "post_reset_px0");
      step(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1, 5'b11111, 1, 0, "post_reset_px1");
      chk_cp("post_reset", 1'b0);

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain obs=%0d exp=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
